// File: rtl/ksa32_sum_pipe.sv
// Kogge-Stone sum stage: carries from group G/P, sum = P_bit ^ c, carry-out and optional signed overflow (KSA_SUM_OVF_EN).
// Latency 1 cycle; full throughput through a main register plus one skid register.
// Backpressure: in_ready = !skid_valid, registered-derived, no combinational path from out_ready.
module ksa32_sum_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] G_grp,
    input  logic [31:0] P_grp,
    input  logic [31:0] P_bit,
    input  logic        c_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] sum,
    output logic        c_out,
    output logic        ovf
);

    // c[i+1] = G[i:0] | P[i:0] & c_in; c[0] = c_in
    logic [32:0] carry;
    logic [31:0] sum_dat;
    logic        accept;
    logic        drain;

    logic        m_vld;
    logic [31:0] m_sum;
    logic        m_cout;
    logic        s_vld;
    logic [31:0] s_sum;
    logic        s_cout;

    assign carry    = {G_grp | (P_grp & {32{c_in}}), c_in};
    assign sum_dat  = P_bit ^ carry[31:0];

    assign in_ready  = rst_n & ~s_vld;
    assign out_valid = m_vld;
    assign sum       = m_sum;
    assign c_out     = m_cout;
    assign accept    = in_valid & in_ready;
    assign drain     = m_vld & out_ready;

`ifdef KSA_SUM_OVF_EN
    logic ovf_dat;
    logic m_ovf;
    logic s_ovf;

    assign ovf_dat = carry[31] ^ carry[32];
    assign ovf     = m_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_ovf <= 1'b0;
            s_ovf <= 1'b0;
        end else if (!m_vld) begin
            if (accept) m_ovf <= ovf_dat;
        end else if (!s_vld) begin
            if (accept && drain)  m_ovf <= ovf_dat;
            else if (accept)      s_ovf <= ovf_dat;
        end else if (drain) begin
            m_ovf <= s_ovf;
        end
    end
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_vld  <= 1'b0;
            m_sum  <= 32'd0;
            m_cout <= 1'b0;
            s_vld  <= 1'b0;
            s_sum  <= 32'd0;
            s_cout <= 1'b0;
        end else if (!m_vld) begin
            if (accept) begin
                m_vld  <= 1'b1;
                m_sum  <= sum_dat;
                m_cout <= carry[32];
            end
        end else if (!s_vld) begin
            if (accept && drain) begin
                m_sum  <= sum_dat;
                m_cout <= carry[32];
            end else if (accept) begin
                s_vld  <= 1'b1;
                s_sum  <= sum_dat;
                s_cout <= carry[32];
            end else if (drain) begin
                m_vld  <= 1'b0;
            end
        end else if (drain) begin
            // skid entry moves up; input was blocked this cycle
            s_vld  <= 1'b0;
            m_sum  <= s_sum;
            m_cout <= s_cout;
        end
    end

endmodule

// File: tb/tb_ksa32_sum_pipe.sv
// Bench for ksa32_sum_pipe: directed vectors, back-pressure, random streaming, mid-operation reset.
module tb_ksa32_sum_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] G_grp;
    logic [31:0] P_grp;
    logic [31:0] P_bit;
    logic        c_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        c_out;
    logic        ovf;

    int n_pass = 0;
    int n_total = 0;

    ksa32_sum_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .G_grp(G_grp), .P_grp(P_grp), .P_bit(P_bit), .c_in(c_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] e_sum;
        logic        e_cout;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // behavioural prefix tree: group G/P over bits [i:0]
    task automatic drive_ops(input logic [31:0] a, input logic [31:0] b, input logic cin);
        logic [32:0] m;
        logic [32:0] s;
        logic [31:0] pb;
        pb = a ^ b;
        for (int i = 0; i < 32; i++) begin
            m = (33'd1 << (i + 1)) - 33'd1;
            s = ({1'b0, a} & m) + ({1'b0, b} & m);
            G_grp[i] = s[i+1];
            P_grp[i] = (({1'b0, pb} & m) == m);
        end
        P_bit = pb;
        c_in  = cin;
    endtask

    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic cin);
        logic [32:0] r;
        logic        v;
        r = {1'b0, a} + {1'b0, b} + {32'd0, cin};
`ifdef KSA_SUM_OVF_EN
        v = (a[31] == b[31]) && (r[31] != a[31]);
`else
        v = 1'b0;
`endif
        return {v, r};
    endfunction

    function automatic logic [33:0] obs();
        return {ovf, c_out, sum};
    endfunction

    logic [33:0] q[$];
    logic [33:0] e;
    logic [33:0] prev_out;
    logic        prev_stall;
    int sent, rcvd, cyc;
    logic [31:0] ra, rb;
    logic        rc;

    initial begin
        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[2] = '{32'h12345678, 32'h0FEDCBA8, 1'b1, 32'h22222221, 1'b0, 1'b0};
        vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[4] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
`ifndef KSA_SUM_OVF_EN
        for (int i = 0; i < 5; i++) vecs[i].e_ovf = 1'b0;
`endif

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive_ops(32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_outputs", {30'd0, obs()}, 64'd0);
        chk("rst_in_ready_low", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_release", {63'd0, in_ready}, 64'd1);

        // directed table, one transfer each with out_ready high
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_ops(vecs[i].a, vecs[i].b, vecs[i].cin);
            in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
            chk($sformatf("vec%0d_result", i), {30'd0, obs()},
                {30'd0, vecs[i].e_ovf, vecs[i].e_cout, vecs[i].e_sum});
        end
        @(posedge clk);
        @(negedge clk);
        chk("drained_empty", {63'd0, out_valid}, 64'd0);

        // back-pressure: three inputs against a stalled consumer
        out_ready = 1'b0;
        drive_ops(32'd1, 32'd1, 1'b0); in_valid = 1'b1;
        chk("bp_rdy1", {63'd0, in_ready}, 64'd1);
        @(posedge clk); @(negedge clk);
        drive_ops(32'd10, 32'd20, 1'b0);
        chk("bp_rdy2", {63'd0, in_ready}, 64'd1);
        @(posedge clk); @(negedge clk);
        drive_ops(32'd100, 32'd200, 1'b1);
        chk("bp_full_rdy", {63'd0, in_ready}, 64'd0);
        chk("bp_head", {30'd0, obs()}, {30'd0, model(32'd1, 32'd1, 1'b0)});
        @(posedge clk); @(negedge clk);
        chk("bp_hold", {30'd0, obs()}, {30'd0, model(32'd1, 32'd1, 1'b0)});
        chk("bp_hold_rdy", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("bp_second", {30'd0, obs()}, {30'd0, model(32'd10, 32'd20, 1'b0)});
        chk("bp_rdy_again", {63'd0, in_ready}, 64'd1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("bp_third", {30'd0, obs()}, {30'd0, model(32'd100, 32'd200, 1'b1)});
        chk("bp_third_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk); @(negedge clk);
        chk("bp_empty", {63'd0, out_valid}, 64'd0);

        // random streaming with scoreboard and stall-stability check
        sent = 0; rcvd = 0; cyc = 0; prev_stall = 1'b0; prev_out = '0;
        while ((rcvd < 1000) && (cyc < 20000)) begin
            if (prev_stall) chk("stream_stable", {30'd0, obs()}, {30'd0, prev_out});
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
            drive_ops(ra, rb, rc);
            in_valid  = (sent < 1000) && ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("stream_spurious", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("stream_data", {30'd0, obs()}, {30'd0, e});
                end
                rcvd++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(ra, rb, rc));
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = obs();
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        chk("stream_count", 64'(rcvd), 64'd1000);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);

        // reset while FULL
        out_ready = 1'b0; in_valid = 1'b1;
        drive_ops(32'd5, 32'd6, 1'b0);
        @(posedge clk); @(negedge clk);
        drive_ops(32'd7, 32'd8, 1'b0);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("mid_full", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_out", {30'd0, obs()}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_rdy", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        drive_ops(32'hDEADBEEF, 32'h21524111, 1'b1);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
        chk("post_rst_result", {30'd0, obs()}, {30'd0, model(32'hDEADBEEF, 32'h21524111, 1'b1)});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
